display_sequencer: RTL and testbench
====================================

Name: display_sequencer

Overview:
Registered controller for the six active-low 7-segment digits (hex5..hex0, bit 7 = DP, all active-low). It converts a 20-bit binary result to six BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. It then selects the display source each cycle by priority: Inf banner, flashing CALC banner, numeric result, operation name. It sits between the calculator datapath/button tracker and the board HEX pins.

Parameters:
FLASH_HALF, 25000000, cycles per CALC-visible phase and per blank phase.
VAL_W, 20, width of the binary input value.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
value  in  VAL_W  binary result to display.
value_load  in  1  one-cycle strobe; latches value and starts conversion.
en_calc  in  1  select numeric display.
zero_check  in  1  divide-by-zero; select Inf banner.
flash_start  in  1  select flashing CALC banner.
buttn_track  in  10  one-hot-ish operation code for the name display.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse, conversion finished.
overflow  out  1  last loaded value exceeds 999999.
hex5..hex0  out  8 each  segment patterns; hex5 is the leftmost digit.

Behaviour:
- Reset (synchronous, priority over everything):
  - hex5..hex0 = 8'hFF; busy = 0; done = 0; overflow = 0.
  - Digit register = 000000; flash counter = 0; FSM = IDLE.
  - Reset during CONV aborts the conversion with no done pulse.
- Encodings:
  - Digits 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - blank FF. Err = 86 AF AF. Inf = F9 8E AB. CALC = C6 88 C7 C6.
- FSM states and transitions:
  - IDLE --value_load--> CONV.
  - CONV: 20 iterations, then --> IDLE.
- Load and overflow:
  - value_load at edge N latches value.
  - If value > 999999: overflow = 1 from N+1; FSM stays IDLE; no conversion; done pulses at N+1.
  - Otherwise: overflow = 0 from N+1; busy = 1 for edges N+1..N+20; done = 1 for one cycle at N+21 with busy = 0.
  - The digit register updates atomically at N+21. The numeric display never shows partial BCD.
- value_load during CONV restarts the conversion with the new value; no done pulse for the aborted value.
- Shift-add-3 step: each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit, feeding in the value MSB first.
- Display select (registered; one-cycle latency from select inputs to hex):
  1. zero_check = 1: hex5..hex3 = Inf; hex2..hex0 = FF.
  2. else flash_start = 1: hex5..hex2 = CALC for FLASH_HALF cycles, then all FF for FLASH_HALF cycles, repeating. CALC is visible on the first cycle after flash_start rises. The counter clears to 0 whenever flash_start = 0 or zero_check = 1.
  3. else en_calc = 1 and overflow = 1: hex5..hex3 = Err; hex2..hex0 = FF.
  4. else en_calc = 1: show the digit register. While busy, the previous result is held.
  5. else buttn_track selects an operation name; unlisted codes give all FF:
     - 0x001: hex5..3 = 88 A1 A1.
     - 0x002: hex5..3 = 92 E3 83.
     - 0x004: hex5..2 = C8 C8 E3 C7.
     - 0x008: hex5..3 = C0 FB E3.
     - 0x201: hex5..2 = C7 A3 90 A4.
     - Remaining digits FF.
- Conversion runs independently of the display source. A result converted while the name is shown appears when en_calc rises.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: leading zero digits in numeric mode show FF, scanning from hex5 down; hex0 is always shown, so value 0 shows FF×5, C0.
- Undefined: all six digits are shown, including leading zeros.

Test Plan:
1. reset, en_calc = 1, value = 123456, value_load at edge N -> busy N+1..N+20; done pulse at N+21; hex5..0 = F9 A4 B0 99 92 82 at N+22.
2. value = 1000000 load -> overflow = 1 and done at N+1, no busy; en_calc display = 86 AF AF FF FF FF. Then load 999999 -> overflow = 0; display 90×6 after done.
3. Load 555 then load 42 at N+5 -> exactly one done at N+5+21. Display = C0 C0 C0 C0 99 A4 (FF FF FF FF 99 A4 with LEAD_ZERO_BLANK_EN).
4. FLASH_HALF = 4, flash_start high 20 cycles -> CALC 4 cycles, blank 4, CALC 4...
   - Assert zero_check mid-flash -> Inf next cycle.
   - Deassert -> CALC restarts visible.
5. en_calc = 0, buttn_track = 0x004 -> C8 C8 E3 C7 FF FF. 0x201 -> C7 A3 90 A4 FF FF. 0x010 -> all FF.
6. reset asserted at N+10 of a conversion -> no done; busy = 0; hex all FF; with en_calc = 1 display C0×6 next cycle.

Source files
------------

// File: rtl/display_sequencer.sv
// display_sequencer
// Drives the six active-low 7-segment digits (hex5 leftmost, bit 7 = DP).
// A 20-bit result is converted to six BCD digits by a shift-add-3 engine
// (one bit per cycle). Each cycle the shown source is picked by priority:
// Inf banner, flashing CALC banner, numeric result (or Err), operation name.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   value, value_load   binary result and its one-cycle load strobe
//   en_calc             show the numeric result
//   zero_check          divide-by-zero, show Inf
//   flash_start         show flashing CALC banner
//   buttn_track         operation code for the name display
//   busy, done          conversion running / one-cycle completion pulse
//   overflow            last loaded value exceeded 999999
//   hex5..hex0          registered segment patterns
//
// Build option: define LEAD_ZERO_BLANK_EN to blank leading zeros (hex0 is
// always shown) in numeric mode.
module display_sequencer #(
    parameter int FLASH_HALF = 25000000,
    parameter int VAL_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             value_load,
    input  logic             en_calc,
    input  logic             zero_check,
    input  logic             flash_start,
    input  logic [9:0]       buttn_track,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [7:0]       hex5,
    output logic [7:0]       hex4,
    output logic [7:0]       hex3,
    output logic [7:0]       hex2,
    output logic [7:0]       hex1,
    output logic [7:0]       hex0
);
    // state  | meaning
    // S_IDLE | waiting for value_load
    // S_LOAD | value latched; range check on the next edge
    // S_CONV | shift-add-3 iterations running

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV} state_t;

    localparam int IW = $clog2(VAL_W + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam logic [IW-1:0] ITER_N  = IW'(VAL_W);
    localparam logic [FW-1:0] FL_LAST = FW'(FLASH_HALF - 1);

    state_t           state;
    logic [VAL_W-1:0] val_reg;
    logic [VAL_W-1:0] shift;
    logic [23:0]      bcd;
    logic [23:0]      bcd_adj;
    logic [23:0]      bcd_next;
    logic [23:0]      digits;
    logic [IW-1:0]    iter;
    logic [FW-1:0]    fl_cnt;
    logic             fl_blank;
    logic [47:0]      hex_r;
    logic [47:0]      disp_next;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    function automatic logic [47:0] blank_lead(input logic [47:0] d, input logic [23:0] dig);
        logic [47:0] r;
        logic        lead;
        r    = d;
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (lead && dig[i*4 +: 4] == 4'd0) r[i*8 +: 8] = 8'hFF;
            else lead = 1'b0;
        end
        return r;
    endfunction
`endif

    // One double-dabble step: correct nibbles >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        bcd_next = (bcd_adj << 1) | {23'd0, shift[VAL_W-1]};
    end

    always_comb begin
        disp_next = '1;
        if (zero_check) begin
            disp_next[47:24] = 24'hF98EAB;
        end else if (flash_start) begin
            if (!fl_blank) disp_next[47:16] = 32'hC688C7C6;
        end else if (en_calc && overflow) begin
            disp_next[47:24] = 24'h86AFAF;
        end else if (en_calc) begin
            for (int i = 0; i < 6; i++) disp_next[i*8 +: 8] = seg7(digits[i*4 +: 4]);
`ifdef LEAD_ZERO_BLANK_EN
            disp_next = blank_lead(disp_next, digits);
`endif
        end else begin
            case (buttn_track)
                10'h001: disp_next[47:24] = 24'h88A1A1;
                10'h002: disp_next[47:24] = 24'h92E383;
                10'h004: disp_next[47:16] = 32'hC8C8E3C7;
                10'h008: disp_next[47:24] = 24'hC0FBE3;
                10'h201: disp_next[47:16] = 32'hC7A390A4;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            val_reg  <= '0;
            shift    <= '0;
            bcd      <= '0;
            digits   <= '0;
            iter     <= '0;
            fl_cnt   <= '0;
            fl_blank <= 1'b0;
            hex_r    <= '1;
        end else begin
            done  <= 1'b0;
            hex_r <= disp_next;

            // Flash phase timer; held cleared whenever the banner is not selected
            if (flash_start && !zero_check) begin
                if (fl_cnt == FL_LAST) begin
                    fl_cnt   <= '0;
                    fl_blank <= ~fl_blank;
                end else begin
                    fl_cnt <= fl_cnt + 1'b1;
                end
            end else begin
                fl_cnt   <= '0;
                fl_blank <= 1'b0;
            end

            // A new load always wins, aborting any conversion in flight
            if (value_load) begin
                val_reg <= value;
                state   <= S_LOAD;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (32'(val_reg) > 32'd999999) begin
                            overflow <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            shift    <= val_reg;
                            bcd      <= '0;
                            iter     <= ITER_N;
                            state    <= S_CONV;
                        end
                    end
                    S_CONV: begin
                        bcd   <= bcd_next;
                        shift <= shift << 1;
                        if (iter == IW'(1)) begin
                            digits <= bcd_next;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            iter <= iter - 1'b1;
                        end
                    end
                    S_IDLE:  ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign hex5 = hex_r[47:40];
    assign hex4 = hex_r[39:32];
    assign hex3 = hex_r[31:24];
    assign hex2 = hex_r[23:16];
    assign hex1 = hex_r[15:8];
    assign hex0 = hex_r[7:0];

endmodule

// File: tb/tb_display_sequencer.sv
module tb_display_sequencer;
    localparam int FH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] value;
    logic        value_load;
    logic        en_calc;
    logic        zero_check;
    logic        flash_start;
    logic [9:0]  buttn_track;
    logic        busy, done, overflow;
    logic [7:0]  hex5, hex4, hex3, hex2, hex1, hex0;

    int n_cmp = 0;
    int n_err = 0;
    int m_val = 0;
    bit m_ovf = 1'b0;

    display_sequencer #(.FLASH_HALF(FH), .VAL_W(20)) dut (
        .clk(clk), .reset(reset), .value(value), .value_load(value_load),
        .en_calc(en_calc), .zero_check(zero_check), .flash_start(flash_start),
        .buttn_track(buttn_track), .busy(busy), .done(done), .overflow(overflow),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] hex_all();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    function automatic logic [7:0] seg(input int d);
        logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tab[d];
    endfunction

    // Decimal digits by plain division, then optional leading-zero blanking
    function automatic logic [47:0] num_disp(input int v);
        logic [47:0] r;
        int          d [6];
        int          t;
        t = v;
        for (int i = 0; i < 6; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            r[i*8 +: 8] = seg(d[i]);
        end
`ifdef LEAD_ZERO_BLANK_EN
        for (int i = 5; i >= 1; i--) begin
            if (d[i] != 0) break;
            r[i*8 +: 8] = 8'hFF;
        end
`endif
        return r;
    endfunction

    function automatic logic [47:0] name_disp(input logic [9:0] c);
        case (c)
            10'h001: return 48'h88A1A1_FFFFFF;
            10'h002: return 48'h92E383_FFFFFF;
            10'h004: return 48'hC8C8E3C7_FFFF;
            10'h008: return 48'hC0FBE3_FFFFFF;
            10'h201: return 48'hC7A390A4_FFFF;
            default: return '1;
        endcase
    endfunction

    // fk = cycles the flash banner has already been active before this edge
    function automatic logic [47:0] exp_disp(input int fk, input bit ovf, input int val);
        if (zero_check)        return 48'hF98EAB_FFFFFF;
        if (flash_start)       return ((fk / FH) % 2 == 0) ? 48'hC688C7C6_FFFF : '1;
        if (en_calc && ovf)    return 48'h86AFAF_FFFFFF;
        if (en_calc)           return num_disp(val);
        return name_disp(buttn_track);
    endfunction

    // Load v and follow the 22 edges after the load edge, checking timing and display
    task automatic do_load(input int v);
        int old_val = m_val;
        bit old_ovf = m_ovf;
        bit new_ovf = (v > 999999);
        value = 20'(v);
        value_load = 1'b1;
        tick;
        value_load = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            bit eb, ed, ou;
            int vu;
            tick;
            eb = !new_ovf && k <= 20;
            ed = new_ovf ? (k == 1) : (k == 21);
            ou = (k >= 2) ? new_ovf : old_ovf;
            vu = (!new_ovf && k >= 22) ? v : old_val;
            chk($sformatf("busy v=%0d k=%0d", v, k), 48'(busy), 48'(eb));
            chk($sformatf("done v=%0d k=%0d", v, k), 48'(done), 48'(ed));
            chk($sformatf("ovf v=%0d k=%0d", v, k), 48'(overflow), 48'(new_ovf));
            chk($sformatf("hex v=%0d k=%0d", v, k), hex_all(), exp_disp(0, ou, vu));
        end
        m_ovf = new_ovf;
        if (!new_ovf) m_val = v;
    endtask

    initial begin
        int         dcnt;
        int         dedge;
        int         v;
        logic [9:0] codes [8] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h201, 10'h010, 10'h000, 10'h3FF};

        reset = 1'b1; value = '0; value_load = 1'b0; en_calc = 1'b0;
        zero_check = 1'b0; flash_start = 1'b0; buttn_track = '0;
        tick;
        chk("rst hex", hex_all(), '1);
        chk("rst busy", 48'(busy), 48'(0));
        chk("rst done", 48'(done), 48'(0));
        chk("rst ovf", 48'(overflow), 48'(0));
        tick;
        reset = 1'b0;
        en_calc = 1'b1;
        tick;
        chk("rst digits", hex_all(), num_disp(0));

        do_load(123456);
        chk("hex 123456", hex_all(), 48'hF9A4B0999282);
        do_load(1000000);
        chk("hex err", hex_all(), 48'h86AFAF_FFFFFF);
        do_load(999999);
        chk("hex 999999", hex_all(), 48'h909090909090);
        do_load(0);

        for (int i = 0; i < 8; i++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000000, 1048575))
                                            : int'($urandom_range(0, 999999));
            do_load(v);
        end

        // restart: 555 at N, 42 at N+5
        do_load(7);
        value = 20'd555; value_load = 1'b1;
        tick;
        value_load = 1'b0;
        dcnt = 0; dedge = -1;
        for (int k = 1; k <= 27; k++) begin
            if (k == 5) begin
                value = 20'd42; value_load = 1'b1;
            end
            tick;
            value_load = 1'b0;
            if (done) begin
                dcnt++;
                dedge = k;
            end
        end
        chk("restart done count", 48'(dcnt), 48'(1));
        chk("restart done edge", 48'(dedge), 48'(26));
        m_val = 42; m_ovf = 1'b0;
        chk("restart hex", hex_all(), num_disp(42));

        // flash banner
        flash_start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            chk($sformatf("flash k=%0d", k), hex_all(), exp_disp(k, m_ovf, m_val));
        end
        zero_check = 1'b1;
        tick;
        chk("inf 0", hex_all(), 48'hF98EAB_FFFFFF);
        tick;
        chk("inf 1", hex_all(), exp_disp(0, m_ovf, m_val));
        zero_check = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("reflash k=%0d", k), hex_all(), exp_disp(k, m_ovf, m_val));
        end
        flash_start = 1'b0;
        tick;
        chk("flash off", hex_all(), num_disp(m_val));

        // operation names
        en_calc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            buttn_track = (i < 8) ? codes[i] : 10'($urandom_range(0, 1023));
            tick;
            chk($sformatf("name %h", buttn_track), hex_all(), name_disp(buttn_track));
        end

        // reset mid-conversion
        en_calc = 1'b1;
        value = 20'($urandom_range(1, 999999)); value_load = 1'b1;
        tick;
        value_load = 1'b0;
        for (int k = 1; k <= 9; k++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid rst hex", hex_all(), '1);
        chk("mid rst busy", 48'(busy), 48'(0));
        chk("mid rst done", 48'(done), 48'(0));
        m_val = 0; m_ovf = 1'b0;
        tick;
        chk("mid rst digits", hex_all(), num_disp(0));
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick;
            if (done) dcnt++;
        end
        chk("mid rst no done", 48'(dcnt), 48'(0));
        chk("mid rst busy after", 48'(busy), 48'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
